ifu_prefetch: RTL and testbench

//   Instruction-fetch front end between the PC/instruction memory and decode. Generates sequential

---
 rtl/ifu_prefetch_pkg.sv | 25 ++
 rtl/ifu_prefetch_fetch_fifo.sv | 80 ++++++++
 rtl/ifu_prefetch.sv | 134 +++++++++++++
 tb/tb_ifu_prefetch.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_prefetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package ifu_prefetch_pkg;

  localparam int unsigned XLEN      = 64;
  localparam int unsigned ILEN      = 32;
  localparam int unsigned IFU_DEPTH = 4;

  localparam logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ifu_state_e;

  // Instructions are word aligned; the low two PC bits carry no information.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_prefetch_fetch_fifo.sv
// Small synchronous queue of fetched instructions with a registered head entry.
module fetch_fifo
  import ifu_prefetch_pkg::*;
#(
  parameter int unsigned DEPTH = IFU_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     valid,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_nxt;
  logic [PW-1:0] rd_nxt;
  logic [PW-1:0] cnt_left;
  logic [PW-1:0] cnt_nxt;
  logic          push_ok;
  logic          pop_ok;
  logic          full;
  fetch_entry_t  head_nxt;

  // Next pointers and the entry that will sit at the head after this edge.
  always_comb begin
    pop_ok   = pop && valid && !flush;
    push_ok  = push && !flush;
    full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    rd_nxt   = rd_ptr + PW'(pop_ok);
    wr_nxt   = wr_ptr + PW'(push_ok);
    cnt_left = count - PW'(pop_ok);
    cnt_nxt  = cnt_left + PW'(push_ok);
    head_nxt = mem[rd_nxt[AW-1:0]];
    if (push_ok && (cnt_left == '0)) begin
      head_nxt = push_data;
    end
    if (flush) begin
      rd_nxt   = '0;
      wr_nxt   = '0;
      cnt_nxt  = '0;
      head_nxt = head;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      head   <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
      end
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      count  <= cnt_nxt;
      valid  <= (cnt_nxt != '0);
      head   <= head_nxt;
    end
  end

  // The fetch credit scheme must never let a response land in a full queue.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push_ok && !pop_ok && full));

endmodule

// File: rtl/ifu_prefetch.sv
// Fetch front end: sequential request generation, in-order response buffering,
// and redirect handling that flushes the queue and drops stale responses.
module ifu_prefetch
  import ifu_prefetch_pkg::*;
#(
  parameter int unsigned DEPTH = IFU_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [XLEN-1:0]  imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [ILEN-1:0]  imem_rsp_data,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [XLEN-1:0]  inst_pc,
  output logic [ILEN-1:0]  inst
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = CW + 1;

  ifu_state_e       state;
  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  rsp_pc;
  logic [CW-1:0]    inflight;
  logic [CW-1:0]    discard;
  logic [CW-1:0]    count;

  logic [XLEN-1:0]  redirect_base;
  logic [XLEN-1:0]  fetch_pc_nxt;
  logic [XLEN-1:0]  rsp_pc_nxt;
  logic [CW-1:0]    inflight_nxt;
  logic [CW-1:0]    discard_nxt;
  logic [CW-1:0]    count_nxt;
  logic             req_fire;
  logic             rsp_push;
  logic             pop_eff;
  logic             req_valid_nxt;
  fetch_entry_t     push_entry;
  fetch_entry_t     head;

  assign imem_req_addr = fetch_pc;
  assign inst_pc       = head.pc;
  assign inst          = head.inst;

  // Counter updates; a redirect overrides everything else in its cycle.
  always_comb begin
    req_fire      = imem_req_valid && imem_req_ready;
    redirect_base = align_pc(redirect_pc);
    rsp_push      = imem_rsp_valid && !redirect_valid && (discard == '0);
    pop_eff       = inst_valid && inst_ready && !redirect_valid;
    push_entry    = '{pc: rsp_pc, inst: imem_rsp_data};

    inflight_nxt  = inflight + CW'(req_fire) - CW'(imem_rsp_valid);

    discard_nxt   = discard;
    if (redirect_valid) begin
      discard_nxt = inflight_nxt;
    end else if (imem_rsp_valid && (discard != '0)) begin
      discard_nxt = discard - CW'(1);
    end

    fetch_pc_nxt  = fetch_pc + XLEN'({req_fire, 2'b00});
    rsp_pc_nxt    = rsp_pc + XLEN'({rsp_push, 2'b00});
    count_nxt     = count + CW'(rsp_push) - CW'(pop_eff);
    if (redirect_valid) begin
      fetch_pc_nxt = redirect_base;
      rsp_pc_nxt   = redirect_base;
      count_nxt    = '0;
    end

    // Credit: outstanding requests plus buffered entries never exceed the queue size.
    req_valid_nxt = (SW'(inflight_nxt) + SW'(count_nxt)) < SW'(DEPTH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      fetch_pc       <= RESET_PC;
      rsp_pc         <= RESET_PC;
      inflight       <= '0;
      discard        <= '0;
      imem_req_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state          <= RUN;
          imem_req_valid <= req_valid_nxt;
        end
        RUN: begin
          state          <= RUN;
          imem_req_valid <= req_valid_nxt;
        end
      endcase
      fetch_pc <= fetch_pc_nxt;
      rsp_pc   <= rsp_pc_nxt;
      inflight <= inflight_nxt;
      discard  <= discard_nxt;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_push),
    .push_data (push_entry),
    .pop       (inst_ready),
    .flush     (redirect_valid),
    .valid     (inst_valid),
    .head      (head),
    .count     (count)
  );

  a_discard_bound: assert property (@(posedge clk) disable iff (rst)
    discard <= inflight);

  a_credit_bound: assert property (@(posedge clk) disable iff (rst)
    (SW'(inflight) + SW'(count)) <= SW'(DEPTH));

  a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> (inflight != '0));

  // A pending request may only be withdrawn or retargeted by a redirect.
  a_req_hold: assert property (@(posedge clk) disable iff (rst)
    (imem_req_valid && !imem_req_ready && !redirect_valid)
      |=> (imem_req_valid && $stable(imem_req_addr)));

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch with a request-list model checked every cycle.
module tb_ifu_prefetch;

  localparam int          DEPTH  = 4;
  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [63:0] inst_pc;
  logic [31:0] inst;

  always #5 clk = ~clk;

  ifu_prefetch dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_pc        (inst_pc),
    .inst           (inst)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: requested addresses still owed by memory (with stale marks) and the decode queue.
  logic        m_req_valid = 1'b0;
  logic [63:0] m_fetch_pc  = RST_PC;
  logic [63:0] m_q_pc[$];
  logic [31:0] m_q_inst[$];
  logic [63:0] out_addr[$];
  logic        out_stale[$];
  logic [63:0] fired_log[$];
  logic [63:0] popped_log[$];

  logic        k_rst = 1'b1;
  logic        k_mem_ready = 1'b0;
  logic        k_rsp_en = 1'b0;
  logic        k_inst_ready = 1'b0;
  logic        k_redir = 1'b0;
  logic [63:0] k_redir_pc = '0;

  function automatic logic [31:0] mkdata(input logic [63:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    m_req_valid = 1'b0;
    m_fetch_pc  = RST_PC;
    m_q_pc.delete();
    m_q_inst.delete();
    out_addr.delete();
    out_stale.delete();
  endtask

  task automatic compare();
    chk("req_valid", 64'(imem_req_valid), 64'(m_req_valid));
    chk("req_addr", imem_req_addr, m_fetch_pc);
    chk("inst_valid", 64'(inst_valid), 64'(m_q_pc.size() != 0));
    if (m_q_pc.size() != 0) begin
      chk("inst_pc", inst_pc, m_q_pc[0]);
      chk("inst", 64'(inst), 64'(m_q_inst[0]));
    end
  endtask

  // Called at a falling edge: check, drive this cycle's inputs, advance the model.
  task automatic cycle();
    logic        fire;
    logic        rsp;
    logic        pop;
    logic        st;
    logic [63:0] a;
    compare();
    rst            = k_rst;
    rsp            = !k_rst && k_rsp_en && (out_addr.size() > 0);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mkdata(out_addr[0]) : 32'h0;
    imem_req_ready = k_mem_ready;
    inst_ready     = k_inst_ready;
    redirect_valid = k_redir && !k_rst;
    redirect_pc    = k_redir_pc;
    if (k_rst) begin
      clear_model();
    end else begin
      fire = m_req_valid && k_mem_ready;
      pop  = (m_q_pc.size() > 0) && k_inst_ready && !k_redir;
      if (pop) begin
        popped_log.push_back(m_q_pc[0]);
        void'(m_q_pc.pop_front());
        void'(m_q_inst.pop_front());
      end
      if (rsp) begin
        a  = out_addr.pop_front();
        st = out_stale.pop_front();
        if (!st && !k_redir) begin
          m_q_pc.push_back(a);
          m_q_inst.push_back(mkdata(a));
        end
      end
      if (fire) begin
        out_addr.push_back(m_fetch_pc);
        out_stale.push_back(1'b0);
        fired_log.push_back(m_fetch_pc);
        m_fetch_pc = m_fetch_pc + 64'd4;
      end
      if (k_redir) begin
        m_q_pc.delete();
        m_q_inst.delete();
        foreach (out_stale[i]) out_stale[i] = 1'b1;
        m_fetch_pc = {k_redir_pc[63:2], 2'b00};
      end
      m_req_valid = (out_addr.size() + m_q_pc.size()) < DEPTH;
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_inst_valid", 64'(inst_valid), 64'd0);
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_req_addr", imem_req_addr, RST_PC);
    chk("rst_inst_pc", inst_pc, 64'd0);
    chk("rst_inst", 64'(inst), 64'd0);
    clear_model();
    k_rst = 1'b1;
    k_redir = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    @(negedge clk);
    run(2);
    k_rst = 1'b0;
  endtask

  initial begin
    int b;
    int p;
    @(negedge clk);

    // Streaming with everything ready
    do_reset();
    k_mem_ready = 1'b1; k_rsp_en = 1'b1; k_inst_ready = 1'b1;
    b = fired_log.size(); p = popped_log.size();
    run(12);
    chk("t1_req0", fired_log[b], 64'h8000_0000);
    chk("t1_req1", fired_log[b+1], 64'h8000_0004);
    chk("t1_req2", fired_log[b+2], 64'h8000_0008);
    chk("t1_pop0", popped_log[p], 64'h8000_0000);
    chk("t1_pop2", popped_log[p+2], 64'h8000_0008);
    p = popped_log.size();
    run(6);
    chk("t1_steady_pops", 64'(popped_log.size() - p), 64'd6);

    // Decode stalled: credit stops at DEPTH
    do_reset();
    k_mem_ready = 1'b1; k_rsp_en = 1'b1; k_inst_ready = 1'b0;
    b = fired_log.size();
    run(12);
    chk("t2_fires", 64'(fired_log.size() - b), 64'd4);
    chk("t2_req_valid", 64'(imem_req_valid), 64'd0);
    chk("t2_inst_valid", 64'(inst_valid), 64'd1);
    k_inst_ready = 1'b1;
    p = popped_log.size();
    run(10);
    chk("t2_resume_pops", 64'(popped_log.size() - p), 64'd10);

    // Memory back-pressure holds the request
    do_reset();
    k_mem_ready = 1'b0; k_rsp_en = 1'b1; k_inst_ready = 1'b1;
    b = fired_log.size();
    run(6);
    chk("t3_req_valid", 64'(imem_req_valid), 64'd1);
    chk("t3_req_addr", imem_req_addr, 64'h8000_0000);
    chk("t3_no_fire", 64'(fired_log.size() - b), 64'd0);
    k_mem_ready = 1'b1;
    run(3);
    chk("t3_first_fire", fired_log[b], 64'h8000_0000);

    // Redirect with three stale requests outstanding
    do_reset();
    k_mem_ready = 1'b1; k_rsp_en = 1'b0; k_inst_ready = 1'b0;
    b = fired_log.size();
    for (int i = 0; i < 20 && (fired_log.size() - b) < 4; i++) cycle();
    chk("t4_fires", 64'(fired_log.size() - b), 64'd4);
    k_mem_ready = 1'b0; k_rsp_en = 1'b1;
    cycle();
    k_redir = 1'b1; k_redir_pc = 64'h8000_0103; k_rsp_en = 1'b0;
    p = popped_log.size(); b = fired_log.size();
    cycle();
    k_redir = 1'b0;
    chk("t4_flushed", 64'(inst_valid), 64'd0);
    chk("t4_req_valid", 64'(imem_req_valid), 64'd1);
    chk("t4_req_addr", imem_req_addr, 64'h8000_0100);
    k_mem_ready = 1'b1; k_rsp_en = 1'b1; k_inst_ready = 1'b1;
    run(10);
    chk("t4_fire_after", fired_log[b], 64'h8000_0100);
    chk("t4_pop_after", popped_log[p], 64'h8000_0100);

    // Redirect colliding with fire, response and pop; then back-to-back redirects
    run(5);
    chk("t5_busy", 64'(inst_valid), 64'd1);
    k_redir = 1'b1; k_redir_pc = 64'h8000_2000;
    cycle();
    k_redir = 1'b0;
    chk("t5_flushed", 64'(inst_valid), 64'd0);
    run(5);
    k_redir = 1'b1; k_redir_pc = 64'h9000_0000;
    cycle();
    k_redir_pc = 64'hA000_0012;
    p = popped_log.size();
    cycle();
    k_redir = 1'b0;
    b = fired_log.size();
    chk("t5_last_wins", imem_req_addr, 64'hA000_0010);
    run(10);
    chk("t5_fire_after", fired_log[b], 64'hA000_0010);
    chk("t5_pop_after", popped_log[p], 64'hA000_0010);

    // Reset while the queue holds entries
    do_reset();
    k_mem_ready = 1'b1; k_rsp_en = 1'b1; k_inst_ready = 1'b0;
    for (int i = 0; i < 20 && m_q_pc.size() < 2; i++) cycle();
    chk("t6_half_full", 64'(inst_valid), 64'd1);
    do_reset();
    k_inst_ready = 1'b1;
    b = fired_log.size(); p = popped_log.size();
    run(6);
    chk("t6_restart_fire", fired_log[b], RST_PC);
    chk("t6_restart_pop", popped_log[p], RST_PC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
